// File: rtl/hic8_pkg.sv
// Shared mode encodings and sequencer state type for the HIC8 counter initiator.
package hic8_pkg;

  localparam logic [1:0] HIC8_HOLD = 2'd0;
  localparam logic [1:0] HIC8_UP   = 2'd1;
  localparam logic [1:0] HIC8_DOWN = 2'd2;
  localparam logic [1:0] HIC8_LOAD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    FIN
  } seq_state_t;

endpackage

// File: rtl/hic8_seq_timer.sv
// Loadable phase down-counter; expire flags the last enabled cycle of a phase.
module hic8_seq_timer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             en,
  output logic             expire
);

  logic [LEN_W-1:0] count;

  // Saturates at zero so a phase of maximum length never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == LEN_W'(1));

endmodule

// File: rtl/hic8_seq_ctrl.sv
// Start/busy/done sequencer driving a HIC8 counter: load, count up, count down, capture.
// Optional macro HIC8_SEQ_CARRY_STOP_EN lets cout_in cut a counting phase short.
module hic8_seq_ctrl
  import hic8_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     load_val,
  input  logic [LEN_W-1:0] up_len,
  input  logic [LEN_W-1:0] dn_len,
  input  logic [W-1:0]     fout_in,
  input  logic             cout_in,
  output logic [1:0]       m_out,
  output logic [W-1:0]     pin_out,
  output logic             cin_out,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             carry_seen
);

  seq_state_t       state, state_nxt;
  logic [W-1:0]     load_q;
  logic [LEN_W-1:0] up_q, dn_q;
  logic [W-1:0]     result_q;
  logic             done_q;
  logic             accept, counting, carry_hit, expire, phase_end;
  logic             tmr_load;
  logic [LEN_W-1:0] tmr_len;

  assign accept   = (state == IDLE) && start;
  assign counting = (state == UP) || (state == DOWN);

`ifdef HIC8_SEQ_CARRY_STOP_EN
  logic carry_q;

  assign carry_hit = counting && cout_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if (carry_hit) begin
      carry_q <= 1'b1;
    end
  end

  assign carry_seen = carry_q;
`else
  logic unused_cout;

  assign unused_cout = cout_in;
  assign carry_hit   = 1'b0;
  assign carry_seen  = 1'b0;
`endif

  assign phase_end = expire || carry_hit;

  // Timer is primed in LOAD for the first non-empty phase, and again when UP hands over to DOWN.
  assign tmr_load = (state == LOAD) || ((state == UP) && phase_end);
  assign tmr_len  = ((state == LOAD) && (up_q != '0)) ? up_q : dn_q;

  hic8_seq_timer #(
    .LEN_W (LEN_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .len    (tmr_len),
    .en     (counting),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (up_q != '0)      state_nxt = UP;
        else if (dn_q != '0) state_nxt = DOWN;
        else                 state_nxt = FIN;
      end
      UP:   if (phase_end) state_nxt = (dn_q != '0) ? DOWN : FIN;
      DOWN: if (phase_end) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_out   = HIC8_HOLD;
    cin_out = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE: busy = 1'b0;
      LOAD: m_out = HIC8_LOAD;
      UP: begin
        m_out   = HIC8_UP;
        cin_out = 1'b1;
      end
      DOWN: begin
        m_out   = HIC8_DOWN;
        cin_out = 1'b1;
      end
      FIN: m_out = HIC8_HOLD;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      load_q   <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FIN);
      if (accept) begin
        load_q <= load_val;
        up_q   <= up_len;
        dn_q   <= dn_len;
      end
      if (state == FIN) begin
        result_q <= fout_in;
      end
    end
  end

  assign pin_out = load_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_hic8_seq_ctrl.sv
// Self-checking bench for hic8_seq_ctrl with a behavioural HIC8 counter model.
module tb_hic8_seq_ctrl;

`ifdef HIC8_SEQ_CARRY_STOP_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] load_val, up_len, dn_len;
  logic [7:0] fout_in;
  logic       cout_in;
  logic [1:0] m_out;
  logic [7:0] pin_out;
  logic       cin_out, busy, done;
  logic [7:0] result;
  logic       carry_seen;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hic8_seq_ctrl #(
    .W     (8),
    .LEN_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_val   (load_val),
    .up_len     (up_len),
    .dn_len     (dn_len),
    .fout_in    (fout_in),
    .cout_in    (cout_in),
    .m_out      (m_out),
    .pin_out    (pin_out),
    .cin_out    (cin_out),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_seen (carry_seen)
  );

  // Behavioural HIC8: 0 hold, 1 up, 2 down (gated by cin), 3 parallel load.
  logic [7:0] cnt = 8'h00;
  always @(posedge clk) begin
    case (m_out)
      2'd1: if (cin_out) cnt <= cnt + 8'd1;
      2'd2: if (cin_out) cnt <= cnt - 8'd1;
      2'd3: cnt <= pin_out;
      default: cnt <= cnt;
    endcase
  end
  assign fout_in = cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [1:0] exp_mode(input int k, input int ul, input int dl);
    if (k == 1)                return 2'd3;
    else if (k <= 1 + ul)      return 2'd1;
    else if (k <= 1 + ul + dl) return 2'd2;
    else                       return 2'd0;
  endfunction

  task automatic pulse_start(input logic [7:0] lv, input logic [7:0] ul, input logic [7:0] dl);
    @(negedge clk);
    load_val = lv;
    up_len   = ul;
    dn_len   = dl;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    // Scramble inputs to prove the sequence uses latched copies.
    load_val = ~lv;
    up_len   = 8'd3;
    dn_len   = 8'd3;
  endtask

  typedef struct {
    logic [7:0] lv;
    logic [7:0] ul;
    logic [7:0] dl;
    logic [7:0] exp_res;
    int         exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int         dcyc  = -1;
    int         ndone = 0;
    int         merr  = 0;
    int         ul    = int'(v.ul);
    int         dl    = int'(v.dl);
    logic [7:0] res   = 8'h00;
    logic [1:0] em;
    pulse_start(v.lv, v.ul, v.dl);
    for (int k = 1; k <= v.exp_done + 2; k++) begin
      @(negedge clk);
      em = exp_mode(k, ul, dl);
      if (k < v.exp_done) begin
        if (m_out !== em) merr++;
        if (cin_out !== ((em == 2'd1) || (em == 2'd2))) merr++;
        if (busy !== (k <= ul + dl + 2)) merr++;
        if ((k == 1) && (pin_out !== v.lv)) merr++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = k;
          res  = result;
        end
      end
    end
    chk({tag, "_done_cycle"}, dcyc, v.exp_done);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_mode_seq_errors"}, merr, 0);
    chk({tag, "_result"}, int'(res), int'(v.exp_res));
  endtask

  vec_t vecs[6];

  initial begin
    int         dcyc, ndone, nup;
    logic [7:0] res;
    logic [1:0] m5;
    logic       cs5;

    vecs[0] = '{lv: 8'h10, ul: 8'd5,   dl: 8'd2,   exp_res: 8'h13, exp_done: 10};
    vecs[1] = '{lv: 8'h55, ul: 8'd0,   dl: 8'd0,   exp_res: 8'h55, exp_done: 3};
    vecs[2] = '{lv: 8'h20, ul: 8'd0,   dl: 8'd3,   exp_res: 8'h1D, exp_done: 6};
    vecs[3] = '{lv: 8'hFE, ul: 8'd4,   dl: 8'd0,   exp_res: 8'h02, exp_done: 7};
    vecs[4] = '{lv: 8'h00, ul: 8'd1,   dl: 8'd1,   exp_res: 8'h00, exp_done: 5};
    vecs[5] = '{lv: 8'h80, ul: 8'd255, dl: 8'd255, exp_res: 8'h80, exp_done: 513};

    rst_n    = 1'b0;
    start    = 1'b0;
    load_val = 8'h00;
    up_len   = 8'h00;
    dn_len   = 8'h00;
    cout_in  = 1'b0;
    #3;
    chk("rst_m_out", int'(m_out), 0);
    chk("rst_pin_out", int'(pin_out), 0);
    chk("rst_cin_out", int'(cin_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_carry_seen", int'(carry_seen), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start pulses during UP must be ignored.
    pulse_start(8'h40, 8'd6, 8'd2);
    dcyc = -1; ndone = 0; nup = 0; res = 8'h00;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (m_out === 2'd1) nup++;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = k;
          res  = result;
        end
      end
      if ((k == 3) || (k == 4)) begin
        start = 1'b1; load_val = 8'h00; up_len = 8'd1; dn_len = 8'd1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_done_cycle", dcyc, 11);
    chk("busy_start_up_cycles", nup, 6);
    chk("busy_start_result", int'(res), 8'h44);

    // Start accepted in the done cycle.
    pulse_start(8'h07, 8'd1, 8'd0);
    repeat (4) @(negedge clk);
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_first_result", int'(result), 8'h08);
    load_val = 8'h30; up_len = 8'd2; dn_len = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_load_mode", int'(m_out), 3);
    chk("b2b_load_busy", int'(busy), 1);
    dcyc = -1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if ((done === 1'b1) && (dcyc < 0)) begin
        dcyc = k;
        res  = result;
      end
    end
    chk("b2b_second_done_cycle", dcyc, 6);
    chk("b2b_second_result", int'(res), 8'h31);

    // Asynchronous reset during UP.
    pulse_start(8'h00, 8'd20, 8'd0);
    repeat (5) @(negedge clk);
    chk("midrst_pre_mode", int'(m_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_out", int'(m_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cin_out", int'(cin_out), 0);
    chk("midrst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // cout_in high during the third UP cycle (cycle 4).
    pulse_start(8'h00, 8'd10, 8'd1);
    dcyc = -1; res = 8'h00; m5 = 2'd0; cs5 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 5) begin
        m5  = m_out;
        cs5 = carry_seen;
      end
      if ((done === 1'b1) && (dcyc < 0)) begin
        dcyc = k;
        res  = result;
        chk("carry_seen_at_done", int'(carry_seen), int'(CARRY_EN));
      end
      cout_in = (k == 4);
    end
    cout_in = 1'b0;
    chk("carry_mode_after_pulse", int'(m5), CARRY_EN ? 2 : 1);
    chk("carry_seen_after_pulse", int'(cs5), int'(CARRY_EN));
    chk("carry_done_cycle", dcyc, CARRY_EN ? 7 : 14);
    chk("carry_result", int'(res), CARRY_EN ? 2 : 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
